// File: rtl/ctl_sequencer_if.sv
// Datapath-side signal bundle for the instruction-cycle sequencer.
// The master modport is the sequencer, which drives the datapath strobes.
// The slave modport is the datapath, which supplies opcode, flags and the memory handshake.
interface ctl_sequencer_if;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       resume;
    logic       inc_pc;
    logic       load_acc;
    logic       load_pc;
    logic       rd;
    logic       wr;
    logic       load_ir;
    logic       datactl_ena;
    logic       halt;
    logic       bus_err;
    logic [1:0] fetch_idx;
    logic       busy;

    modport master (
        input  opcode, zero, mem_ready, resume,
        output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt,
        output bus_err, fetch_idx, busy
    );

    modport slave (
        output opcode, zero, mem_ready, resume,
        input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt,
        input  bus_err, fetch_idx, busy
    );
endinterface

// File: rtl/ctl_sequencer.sv
// Variable-length instruction-cycle controller for the mini CPU.
// Sequence: FETCH(0..F-1) -> DECODE -> EXEC -> OPER -> RETIRE, with JMP and HLT shortcuts.
// Memory states can stall on mem_ready and fall into a sticky error state on timeout.
// Every output is registered and updates on the negedge that enters a state.
module ctl_sequencer #(
    parameter int FETCH_WORDS = 2,
    parameter int MEM_WAIT_EN = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk1,
    input  logic              ena,
    ctl_sequencer_if.master   bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_OPER   = 3'd4;
    localparam logic [2:0] ST_RETIRE = 3'd5;
    localparam logic [2:0] ST_HALTED = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    localparam logic [1:0] LAST_IDX   = 2'(FETCH_WORDS - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    // Opcodes that read memory in EXEC/OPER/RETIRE (ALU ops and LDA).
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
    endfunction

    logic [2:0] state_r, state_nx_s;
    logic [1:0] fidx_r, fidx_nx_s;
    logic [2:0] op_r, op_nx_s;
    logic [7:0] wait_cnt_r, wait_nx_s;
    logic       wait_cap_s, stall_s;

    logic inc_pc_r, load_acc_r, load_pc_r, rd_r, wr_r, load_ir_r, den_r, halt_r;
    logic bus_err_r, busy_r;
    logic [1:0] fetch_idx_r;
    logic inc_pc_s, load_acc_s, load_pc_s, rd_s, wr_s, load_ir_s, den_s, halt_s;
    logic bus_err_s, busy_s;
    logic [1:0] fetch_idx_s;

    // Identify states that may stall on the memory handshake.
    always_comb begin
        wait_cap_s = 1'b0;
        case (state_r)
            ST_FETCH: wait_cap_s = 1'b1;
            ST_EXEC:  wait_cap_s = is_mem_op(op_r);
            ST_OPER:  wait_cap_s = is_mem_op(op_r) || (op_r == OP_STO);
            default:  wait_cap_s = 1'b0;
        endcase
        stall_s = (MEM_WAIT_EN != 0) && wait_cap_s && !bus.mem_ready;
    end

    // Next-state, fetch index, latched opcode and wait counter.
    always_comb begin
        state_nx_s = state_r;
        fidx_nx_s  = fidx_r;
        op_nx_s    = op_r;
        wait_nx_s  = 8'd0;
        if (stall_s) begin
            if (wait_cnt_r == WAIT_LIMIT) begin
                state_nx_s = ST_ERR;
            end else begin
                wait_nx_s = wait_cnt_r + 8'd1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_FETCH;
                    fidx_nx_s  = 2'd0;
                end
                ST_FETCH: begin
                    if (fidx_r == LAST_IDX) begin
                        state_nx_s = ST_DECODE;
                        fidx_nx_s  = 2'd0;
                        op_nx_s    = bus.opcode;
                    end else begin
                        fidx_nx_s = fidx_r + 2'd1;
                    end
                end
                ST_DECODE: begin
                    if (op_r == OP_HLT) begin
                        state_nx_s = ST_HALTED;
                    end else begin
                        state_nx_s = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_r == OP_JMP) begin
                        state_nx_s = ST_FETCH;
                        fidx_nx_s  = 2'd0;
                    end else begin
                        state_nx_s = ST_OPER;
                    end
                end
                ST_OPER: state_nx_s = ST_RETIRE;
                ST_RETIRE: begin
                    state_nx_s = ST_FETCH;
                    fidx_nx_s  = 2'd0;
                end
                ST_HALTED: begin
                    if (bus.resume) begin
                        state_nx_s = ST_FETCH;
                        fidx_nx_s  = 2'd0;
                    end else begin
                        state_nx_s = ST_HALTED;
                    end
                end
                ST_ERR:  state_nx_s = ST_ERR;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Strobe values for the state being entered; a stall re-derives identical values.
    always_comb begin
        inc_pc_s = 1'b0; load_acc_s = 1'b0; load_pc_s = 1'b0; rd_s = 1'b0;
        wr_s = 1'b0; load_ir_s = 1'b0; den_s = 1'b0; halt_s = 1'b0;
        bus_err_s = 1'b0; fetch_idx_s = 2'd0;
        busy_s = (state_nx_s != ST_IDLE) && (state_nx_s != ST_HALTED) && (state_nx_s != ST_ERR);
        case (state_nx_s)
            ST_FETCH: begin
                rd_s        = 1'b1;
                load_ir_s   = 1'b1;
                inc_pc_s    = (fidx_nx_s != 2'd0);
                fetch_idx_s = fidx_nx_s;
            end
            ST_DECODE: begin
                inc_pc_s = 1'b1;
                halt_s   = (op_nx_s == OP_HLT);
            end
            ST_EXEC: begin
                rd_s      = is_mem_op(op_nx_s);
                den_s     = (op_nx_s == OP_STO);
                load_pc_s = (op_nx_s == OP_JMP);
            end
            ST_OPER: begin
                rd_s       = is_mem_op(op_nx_s);
                load_acc_s = is_mem_op(op_nx_s);
                wr_s       = (op_nx_s == OP_STO);
                den_s      = (op_nx_s == OP_STO);
                inc_pc_s   = (op_nx_s == OP_SKZ) && bus.zero;
            end
            ST_RETIRE: begin
                den_s = (op_nx_s == OP_STO);
                rd_s  = is_mem_op(op_nx_s);
            end
            ST_HALTED: halt_s    = 1'b1;
            ST_ERR:    bus_err_s = 1'b1;
            default:   busy_s    = 1'b0;
        endcase
    end

    // State, counters and registered outputs; ena low aborts at once.
    always_ff @(negedge clk1 or negedge ena) begin
        if (!ena) begin
            state_r <= ST_IDLE; fidx_r <= 2'd0; op_r <= 3'd0; wait_cnt_r <= 8'd0;
            inc_pc_r <= 1'b0; load_acc_r <= 1'b0; load_pc_r <= 1'b0; rd_r <= 1'b0;
            wr_r <= 1'b0; load_ir_r <= 1'b0; den_r <= 1'b0; halt_r <= 1'b0;
            bus_err_r <= 1'b0; busy_r <= 1'b0; fetch_idx_r <= 2'd0;
        end else begin
            state_r <= state_nx_s; fidx_r <= fidx_nx_s; op_r <= op_nx_s; wait_cnt_r <= wait_nx_s;
            inc_pc_r <= inc_pc_s; load_acc_r <= load_acc_s; load_pc_r <= load_pc_s; rd_r <= rd_s;
            wr_r <= wr_s; load_ir_r <= load_ir_s; den_r <= den_s; halt_r <= halt_s;
            bus_err_r <= bus_err_s; busy_r <= busy_s; fetch_idx_r <= fetch_idx_s;
        end
    end

    assign bus.inc_pc      = inc_pc_r;
    assign bus.load_acc    = load_acc_r;
    assign bus.load_pc     = load_pc_r;
    assign bus.rd          = rd_r;
    assign bus.wr          = wr_r;
    assign bus.load_ir     = load_ir_r;
    assign bus.datactl_ena = den_r;
    assign bus.halt        = halt_r;
    assign bus.bus_err     = bus_err_r;
    assign bus.fetch_idx   = fetch_idx_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_ctl_sequencer.sv
// Directed bench for ctl_sequencer: default instance, a TIMEOUT=4 instance
// and a single-word-fetch instance with the memory handshake disabled.
module tb_ctl_sequencer;
    localparam logic [7:0] S_INC = 8'b1000_0000;
    localparam logic [7:0] S_ACC = 8'b0100_0000;
    localparam logic [7:0] S_LPC = 8'b0010_0000;
    localparam logic [7:0] S_RD  = 8'b0001_0000;
    localparam logic [7:0] S_WR  = 8'b0000_1000;
    localparam logic [7:0] S_IR  = 8'b0000_0100;
    localparam logic [7:0] S_DEN = 8'b0000_0010;
    localparam logic [7:0] S_HLT = 8'b0000_0001;
    localparam logic [7:0] S_NONE = 8'b0000_0000;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic clk1 = 1'b1;
    logic ena, ena_to, ena_f1;
    int   checks = 0;
    int   errors = 0;

    // Negedges at 5, 15, 25 ...; sampling happens 1 after each posedge.
    always #5 clk1 = ~clk1;

    ctl_sequencer_if bus();
    ctl_sequencer_if bus_to();
    ctl_sequencer_if bus_f1();

    ctl_sequencer u_dut (.clk1(clk1), .ena(ena), .bus(bus.master));
    ctl_sequencer #(.TIMEOUT(4)) u_to (.clk1(clk1), .ena(ena_to), .bus(bus_to.master));
    ctl_sequencer #(.FETCH_WORDS(1), .MEM_WAIT_EN(0)) u_f1 (.clk1(clk1), .ena(ena_f1), .bus(bus_f1.master));

    // Observed vector: {strobes[7:0], fetch_idx[1:0], busy, bus_err}.
    logic [11:0] obs, obs_to, obs_f1;
    assign obs    = {bus.inc_pc, bus.load_acc, bus.load_pc, bus.rd, bus.wr, bus.load_ir,
                     bus.datactl_ena, bus.halt, bus.fetch_idx, bus.busy, bus.bus_err};
    assign obs_to = {bus_to.inc_pc, bus_to.load_acc, bus_to.load_pc, bus_to.rd, bus_to.wr, bus_to.load_ir,
                     bus_to.datactl_ena, bus_to.halt, bus_to.fetch_idx, bus_to.busy, bus_to.bus_err};
    assign obs_f1 = {bus_f1.inc_pc, bus_f1.load_acc, bus_f1.load_pc, bus_f1.rd, bus_f1.wr, bus_f1.load_ir,
                     bus_f1.datactl_ena, bus_f1.halt, bus_f1.fetch_idx, bus_f1.busy, bus_f1.bus_err};

    function automatic logic [11:0] pk(input logic [7:0] s, input logic [1:0] idx,
                                       input logic b, input logic e);
        return {s, idx, b, e};
    endfunction

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset got %b exp %b", obs, 12'h000);
        end
        bus.opcode = OP_LDA; bus.zero = 1'b0; bus.mem_ready = 1'b1; bus.resume = 1'b0;
        ena = 1'b1;
    endtask

    task automatic test_lda();
        logic [11:0] exp_v [7];
        exp_v = '{pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0), pk(S_INC|S_RD|S_IR, 2'd1, 1'b1, 1'b0),
                  pk(S_INC, 2'd0, 1'b1, 1'b0), pk(S_RD, 2'd0, 1'b1, 1'b0),
                  pk(S_RD|S_ACC, 2'd0, 1'b1, 1'b0), pk(S_RD, 2'd0, 1'b1, 1'b0),
                  pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0)};
        step();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL lda cycle %0d got %b exp %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_jmp();
        logic [11:0] exp_v [5];
        bus.opcode = OP_JMP;
        exp_v = '{pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0), pk(S_INC|S_RD|S_IR, 2'd1, 1'b1, 1'b0),
                  pk(S_INC, 2'd0, 1'b1, 1'b0), pk(S_LPC, 2'd0, 1'b1, 1'b0),
                  pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0)};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL jmp cycle %0d got %b exp %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_sto_wait();
        logic [11:0] exp_v [10];
        bus.opcode = OP_STO;
        exp_v = '{pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0), pk(S_INC|S_RD|S_IR, 2'd1, 1'b1, 1'b0),
                  pk(S_INC, 2'd0, 1'b1, 1'b0), pk(S_DEN, 2'd0, 1'b1, 1'b0),
                  pk(S_WR|S_DEN, 2'd0, 1'b1, 1'b0), pk(S_WR|S_DEN, 2'd0, 1'b1, 1'b0),
                  pk(S_WR|S_DEN, 2'd0, 1'b1, 1'b0), pk(S_WR|S_DEN, 2'd0, 1'b1, 1'b0),
                  pk(S_DEN, 2'd0, 1'b1, 1'b0), pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0)};
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            if (i == 4) bus.mem_ready = 1'b0;
            if (i == 7) bus.mem_ready = 1'b1;
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL sto_wait cycle %0d got %b exp %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_skz(input logic z);
        logic [11:0] exp_v [7];
        bus.opcode = OP_SKZ;
        bus.zero   = z;
        exp_v = '{pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0), pk(S_INC|S_RD|S_IR, 2'd1, 1'b1, 1'b0),
                  pk(S_INC, 2'd0, 1'b1, 1'b0), pk(S_NONE, 2'd0, 1'b1, 1'b0),
                  pk(z ? S_INC : S_NONE, 2'd0, 1'b1, 1'b0), pk(S_NONE, 2'd0, 1'b1, 1'b0),
                  pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0)};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL skz zero=%0d cycle %0d got %b exp %b", z, i, obs, exp_v[i]);
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_halt();
        logic [11:0] exp_v [4];
        bus.opcode = OP_HLT;
        exp_v = '{pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0), pk(S_INC|S_RD|S_IR, 2'd1, 1'b1, 1'b0),
                  pk(S_INC|S_HLT, 2'd0, 1'b1, 1'b0), pk(S_HLT, 2'd0, 1'b0, 1'b0)};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL halt entry cycle %0d got %b exp %b", i, obs, exp_v[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs !== pk(S_HLT, 2'd0, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL halt hold cycle %0d got %b exp %b", i, obs, pk(S_HLT, 2'd0, 1'b0, 1'b0));
            end
        end
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        checks++;
        if (obs !== pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL halt resume got %b exp %b", obs, pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        bus.opcode = OP_LDA;
        step();
        step();
        step();
        checks++;
        if (obs !== pk(S_RD, 2'd0, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid exec got %b exp %b", obs, pk(S_RD, 2'd0, 1'b1, 1'b0));
        end
        ena = 1'b0;
        #2;
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid async got %b exp %b", obs, 12'h000);
        end
        step();
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid held got %b exp %b", obs, 12'h000);
        end
        ena = 1'b1;
        step();
        checks++;
        if (obs !== pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid restart got %b exp %b", obs, pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0));
        end
    endtask

    task automatic test_timeout();
        logic [11:0] exp_v [7];
        exp_v = '{pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0), pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0),
                  pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0), pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0),
                  pk(S_NONE, 2'd0, 1'b0, 1'b1), pk(S_NONE, 2'd0, 1'b0, 1'b1),
                  pk(S_NONE, 2'd0, 1'b0, 1'b1)};
        ena_to = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            if (i == 4) bus_to.mem_ready = 1'b1;
            checks++;
            if (obs_to !== exp_v[i]) begin
                errors++;
                $display("FAIL timeout cycle %0d got %b exp %b", i, obs_to, exp_v[i]);
            end
        end
        ena_to = 1'b0;
        #1;
        checks++;
        if (obs_to !== 12'h000) begin
            errors++;
            $display("FAIL timeout clear got %b exp %b", obs_to, 12'h000);
        end
    endtask

    task automatic test_nowait_f1();
        logic [11:0] exp_v [4];
        exp_v = '{pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0), pk(S_INC, 2'd0, 1'b1, 1'b0),
                  pk(S_LPC, 2'd0, 1'b1, 1'b0), pk(S_RD|S_IR, 2'd0, 1'b1, 1'b0)};
        ena_f1 = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if (obs_f1 !== exp_v[i]) begin
                errors++;
                $display("FAIL nowait_f1 cycle %0d got %b exp %b", i, obs_f1, exp_v[i]);
            end
        end
    endtask

    initial begin
        ena = 1'b0; ena_to = 1'b0; ena_f1 = 1'b0;
        bus.opcode = OP_LDA; bus.zero = 1'b0; bus.mem_ready = 1'b1; bus.resume = 1'b0;
        bus_to.opcode = OP_LDA; bus_to.zero = 1'b0; bus_to.mem_ready = 1'b0; bus_to.resume = 1'b0;
        bus_f1.opcode = OP_JMP; bus_f1.zero = 1'b0; bus_f1.mem_ready = 1'b0; bus_f1.resume = 1'b0;
        test_reset();
        test_lda();
        test_jmp();
        test_sto_wait();
        test_skz(1'b1);
        test_skz(1'b0);
        test_halt();
        test_reset_mid();
        test_timeout();
        test_nowait_f1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctl_sequencer.md
Name: ctl_sequencer

Overview:
- Parametrised next-generation instruction-cycle controller for the mini CPU.
- It replaces the fixed 8-state cycle with a variable-length sequence and a configurable number of instruction-fetch words.
- It adds a memory wait-state handshake with a timeout error, and a halt state that can be resumed.
- It drives the same datapath strobes (PC, ACC, IR, RAM rd/wr, data bus enable) from the decoded 3-bit opcode.

Parameters:
- FETCH_WORDS, 2, number of instruction words fetched per instruction (legal 1..4).
- MEM_WAIT_EN, 1, 1 = memory states stall until mem_ready=1; 0 = mem_ready is ignored and every state lasts 1 cycle.
- TIMEOUT, 15, number of consecutive stalled cycles in one state before the error state is entered (legal 1..255).

Ports:
- clk1  in  1  clock; all state and output updates occur on the negedge of clk1.
- ena  in  1  reset, asynchronous, active-low.
- opcode  in  3  opcode field from the IR: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.
- zero  in  1  accumulator-zero flag.
- mem_ready  in  1  RAM/ROM access complete.
- resume  in  1  leave the halt state.
- inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt  out  1 each  datapath strobes.
- bus_err  out  1  memory timeout occurred (sticky).
- fetch_idx  out  2  index of the instruction word currently being fetched.
- busy  out  1  an instruction is in progress.

Behaviour:
- Reset (ena=0): asynchronous; state=IDLE, all outputs 0, fetch_idx=0, wait counter=0. Reset mid-instruction aborts immediately with no partial strobes.
- Output timing: all outputs are registered. Each updates on the negedge that enters a state and takes the value listed for that state; outputs not listed are 0.
- busy=1 in every state except IDLE, HALTED and ERR.
- IDLE: on the first negedge with ena=1, go to FETCH with k=0.
- FETCH(k), k=0..FETCH_WORDS-1:
  - Outputs: rd=1, load_ir=1, inc_pc=(k!=0), fetch_idx=k.
  - Advance to FETCH(k+1), or to DECODE after the last word.
  - On the edge entering DECODE, latch opcode into op_q. All later decisions use op_q.
- DECODE:
  - Outputs: inc_pc=1, halt=(op_q==HLT).
  - Next state: HLT goes to HALTED; all other opcodes go to EXEC.
- EXEC (operand fetch / setup):
  - ADD/ANDD/XORR/LDA: rd=1.
  - STO: datactl_ena=1.
  - JMP: load_pc=1.
  - SKZ: no strobes.
  - Next state: JMP goes to FETCH(0), so JMP is shortened and skips OPER/RETIRE. All other opcodes go to OPER.
- OPER:
  - ADD/ANDD/XORR/LDA: rd=1, load_acc=1.
  - STO: wr=1, datactl_ena=1.
  - SKZ: inc_pc=zero, where zero is sampled on the entering edge.
  - Next state: RETIRE.
- RETIRE:
  - STO: datactl_ena=1 (data hold after write).
  - ALU/LDA: rd=1.
  - SKZ: no strobes.
  - Next state: FETCH(0).
- HALTED: halt=1, held. On a negedge with resume=1, go to FETCH(0) (halt=0 from that edge).
- Wait-capable states (only when MEM_WAIT_EN=1):
  - These are every FETCH(k), EXEC and OPER for ALU/LDA, and OPER for STO.
  - The state advances only on a negedge where mem_ready=1. Otherwise the state and all outputs hold, and the wait counter increments.
  - The wait counter clears on every state change.
  - If a negedge samples mem_ready=0 with the counter already at TIMEOUT-1, go to ERR instead of holding.
- ERR: bus_err=1, all other outputs 0, busy=0. The only exit is reset.
- States that are not wait-capable always advance after exactly 1 cycle.
- With MEM_WAIT_EN=0, every state lasts exactly 1 cycle.
- Instruction length in cycles, with no stalls (F = FETCH_WORDS):
  - ALU/LDA/STO/SKZ: F+4.
  - JMP: F+2.
  - HLT: F+1, then HALTED.
- Simultaneous events: ena=0 overrides everything. In HALTED, resume is ignored unless the state is HALTED on the sampling edge.

Test Plan:
- Reset release, FETCH_WORDS=2, mem_ready=1, opcode=LDA:
  - Required sequence: rd/load_ir (idx0), inc_pc/rd/load_ir (idx1), inc_pc, rd, rd/load_acc, rd, then back to fetch.
  - Total 6 cycles; busy=1 throughout.
- opcode=JMP:
  - load_pc=1 in the 4th cycle.
  - The next cycle shows fetch_idx=0 with rd=load_ir=1, giving a 4-cycle instruction.
- opcode=STO with mem_ready held at 0 for 3 cycles during OPER:
  - wr=1 and datactl_ena=1 are held for 4 cycles.
  - RETIRE then follows with datactl_ena=1 and wr=0.
- SKZ:
  - With zero=1, OPER shows inc_pc=1.
  - With zero=0, OPER shows inc_pc=0.
  - Both cases are 6 cycles long.
- HLT:
  - halt=1 from DECODE onward; busy=0.
  - Hold resume=0 for 10 cycles: the state stays HALTED.
  - Pulse resume=1: the next edge gives rd=load_ir=1 and halt=0.
- TIMEOUT=4, mem_ready=0 in FETCH(0):
  - Outputs are held; on the 4th stalled negedge, bus_err=1 and all strobes are 0.
  - bus_err stays 1 until ena=0.
  - Asserting ena=0 mid-EXEC clears all outputs immediately, without waiting for a clock edge.
